// File: rtl/feature_load_sequencer.sv
// feature_load_sequencer
// Streams one activation tile from the activation SRAM into the feature loader
// staging registers, then offers the tile to the compute array.
//
// Handshakes: a read is issued in any cycle where sram_rd_en_o and sram_gnt_i
// are both 1, and its data returns exactly one cycle later. The tile is
// transferred in any cycle where tile_valid_o and tile_ready_i are both 1;
// tile_valid_o never drops before that cycle.
module feature_load_sequencer #(
   parameter int inputWidth    = 256,
   parameter int elementWidth  = 8,
   parameter int numElements   = 128,
   parameter int addrWidth     = 8,
   parameter int sramAddrWidth = 16
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     start_i,
   input  logic [sramAddrWidth-1:0] base_addr_i,
   input  logic [9:0]               num_elems_i,
   output logic                     sram_rd_en_o,
   output logic [sramAddrWidth-1:0] sram_addr_o,
   input  logic                     sram_gnt_i,
   input  logic [inputWidth-1:0]    sram_rdata_i,
   output logic                     fl_wr_en_o,
   output logic [addrWidth-1:0]     fl_addr_o,
   output logic [inputWidth-1:0]    fl_data_o,
   output logic [9:0]               fl_mask_start_o,
   output logic [9:0]               fl_mask_end_o,
   output logic                     tile_valid_o,
   input  logic                     tile_ready_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [1:0]               dbg_state_o
);

   localparam int E    = inputWidth / elementWidth;
   localparam int MAXB = numElements / E;
   localparam int CW   = $clog2(MAXB + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [sramAddrWidth-1:0] base_q;
   logic [9:0]               n_q;
   logic [CW-1:0]            b_q;
   logic [CW-1:0]            issue_cnt;
   logic [CW-1:0]            write_cnt;
   logic                     wr_en_q;

   logic [9:0]               n_clamp;
   logic [CW-1:0]            b_calc;
   logic                     issued;

   // Clamp the requested count to the loader depth and round up to whole beats.
   always_comb begin
      n_clamp = (num_elems_i > 10'(numElements)) ? 10'(numElements) : num_elems_i;
      b_calc  = CW'((n_clamp + 10'(E - 1)) / 10'(E));
   end

   assign issued = (state_q == S_LOAD) && sram_gnt_i;

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; the last granted beat leads to one WAIT cycle for its write.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = (b_calc == '0) ? S_VALID : S_LOAD;
         S_LOAD:  if (sram_gnt_i && (issue_cnt == CW'(b_q - 1'b1))) state_d = S_WAIT;
         S_WAIT:  state_d = S_VALID;
         S_VALID: if (tile_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Tile parameters, beat counters and the one-cycle delayed write strobe.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         base_q    <= '0;
         n_q       <= '0;
         b_q       <= '0;
         issue_cnt <= '0;
         write_cnt <= '0;
         wr_en_q   <= 1'b0;
      end else begin
         wr_en_q <= issued;
         if (issued) begin
            write_cnt <= issue_cnt;
            issue_cnt <= issue_cnt + 1'b1;
         end
         if ((state_q == S_IDLE) && start_i) begin
            base_q    <= base_addr_i;
            n_q       <= n_clamp;
            b_q       <= b_calc;
            issue_cnt <= '0;
            write_cnt <= '0;
         end
      end
   end

   // Output decode; address buses are forced to 0 when not in use.
   always_comb begin
      sram_rd_en_o    = (state_q == S_LOAD);
      sram_addr_o     = (state_q == S_LOAD) ? base_q + sramAddrWidth'(issue_cnt) : '0;
      fl_wr_en_o      = wr_en_q;
      fl_addr_o       = wr_en_q ? addrWidth'(write_cnt) * addrWidth'(E) : '0;
      fl_data_o       = sram_rdata_i;
      fl_mask_start_o = '0;
      fl_mask_end_o   = (state_q == S_VALID) ? n_q : '0;
      tile_valid_o    = (state_q == S_VALID);
      busy_o          = (state_q != S_IDLE);
      done_o          = (state_q == S_VALID) && tile_ready_i;
      dbg_state_o     = state_q;
   end

endmodule

// File: doc/feature_load_sequencer.md
# feature_load_sequencer

Sequences one activation tile from the shared activation SRAM into the feature loader staging register file. It then presents the tile to the compute array through a valid/ready handshake. The block sits between the activation SRAM read port (arbitrated, with grant), the feature loader write/mask inputs, and the array controller. It issues full-width read beats, forwards returned data as loader writes, and drives the loader masks so that only the requested elements reach the array.

## Interface
- inputWidth, 256, SRAM beat / loader write width in bits
- elementWidth, 8, bits per element; E = inputWidth/elementWidth elements per beat (32)
- numElements, 128, loader depth in elements; must be a multiple of E
- addrWidth, 8, loader element address width
- sramAddrWidth, 16, SRAM word address width
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start_i  in  1  request a tile load; sampled only in IDLE
- base_addr_i  in  sramAddrWidth  first SRAM word of the tile; latched on start
- num_elems_i  in  10  elements to load; latched on start
- sram_rd_en_o  out  1  read request
- sram_addr_o  out  sramAddrWidth  read word address
- sram_gnt_i  in  1  arbiter grant; a read is issued when rd_en and gnt are both 1
- sram_rdata_i  in  inputWidth  read data, valid exactly 1 cycle after an issued read
- fl_wr_en_o  out  1  loader write enable
- fl_addr_o  out  addrWidth  loader element address of the beat
- fl_data_o  out  inputWidth  loader write data, combinational copy of sram_rdata_i
- fl_mask_start_o  out  10  loader mask start, constant 0
- fl_mask_end_o  out  10  loader mask end; 0 except in VALID
- tile_valid_o  out  1  tile ready for the array
- tile_ready_i  in  1  array accepts the tile
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse on tile acceptance

## Operation
- Latched count N = min(num_elems_i, numElements). Beats B = ceil(N/E).
- States:
  - IDLE: start_i=1 latches base_addr, N and B, and clears counters.
    - B>0: go to LOAD.
    - B=0: go to VALID.
  - LOAD:
    - sram_rd_en_o=1.
    - sram_addr_o = base + issue_cnt.
    - Each granted cycle increments issue_cnt.
    - The grant of beat B-1 moves the FSM to WAIT.
    - gnt=0 stalls with address and rd_en held.
  - WAIT: one cycle in which the final write lands, then go to VALID.
  - VALID:
    - tile_valid_o=1 and fl_mask_end_o=N.
    - tile_valid_o stays high until tile_ready_i=1.
    - On the acceptance cycle: done_o=1, next state IDLE, fl_mask_end_o returns to 0 next cycle.
- Write path:
  - fl_wr_en_o is the registered "read issued" flag (rd_en & gnt delayed 1 cycle).
  - fl_addr_o = (beat index of that read) × E, registered alongside.
- Final-beat overfill:
  - The final partial beat writes all E elements.
  - Elements ≥ N are written but masked off by fl_mask_end_o = N.
- start_i outside IDLE is ignored; no queuing.
- fl_mask_start_o is tied to 0.
- Width rules:
  - issue_cnt and write_cnt are ceil(log2(numElements/E + 1)) bits.
  - SRAM address addition wraps modulo 2^sramAddrWidth.

## Timing
- Reset values: state IDLE; all outputs 0; fl_data_o follows sram_rdata_i.
- Full grant, N=128, start at cycle 0:
  - LOAD occupies cycles 1–4, with reads at base..base+3.
  - Writes occur in cycles 2–5 at addresses 0, 32, 64, 96.
  - WAIT is cycle 5.
  - tile_valid_o and fl_mask_end_o=128 rise in cycle 6.
- Load latency = B + 2 cycles from start to tile_valid_o, plus one cycle per denied grant.
- fl_wr_en_o never asserts outside LOAD/WAIT.
- Exactly B write pulses per tile.
- Deasserting grant mid-burst never drops or duplicates a beat.
- Asynchronous reset at any point, including mid-LOAD, returns the FSM to IDLE and zeroes all outputs immediately.
  - Pending returned data is discarded; no write occurs after reset.
- tile_valid_o and tile_ready_i both high in the same cycle counts as acceptance.
  - start_i in that same cycle is ignored, because the FSM is not yet in IDLE.

## Test plan
- N=128, base=0x0100, gnt=1, ready=1 at cycle 6 -> reads 0x100–0x103; writes at addr 0, 32, 64, 96 in cycles 2–5; mask_end=128; done_o pulse in cycle 6.
- N=40, gnt=1 -> 2 beats; writes at addr 0 and 32; tile_valid in cycle 4; fl_mask_end_o=40; mask_end=0 after acceptance.
- N=128 with gnt pattern 1,0,0,1,1,0,1 -> each SRAM address is issued once; 4 writes in order; tile_valid 2 cycles after the 4th grant.
- start_i pulsed during LOAD and during VALID -> ignored; base/N are unchanged; only one done_o pulse.
- Edge counts:
  - N=0 -> tile_valid in cycle 1, no reads, mask_end=0.
  - N=200 -> clamped to 128; 4 beats; mask_end=128.
- Reset and backpressure:
  - nrst low at cycle 3 of a 4-beat load, then restart -> outputs 0 immediately; no stray write; the restarted load completes normally.
  - tile_ready_i held low for 10 cycles -> tile_valid and mask_end are held; no done_o.
